// File: rtl/display_shift_driver.sv
// Shifts a parallel segment frame out to 74HC595-style registers, then pulses the latch.
// Optional build macro: DISPLAY_SHIFT_LSB_FIRST_EN (send bit 0 first instead of the MSB).
module display_shift_driver #(
  parameter int SYS_CLK_HZ   = 5_000_000,
  parameter int SHIFT_CLK_HZ = 1_000_000,
  parameter int NUM_BITS     = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_start,
  input  logic [NUM_BITS-1:0] i_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_serial_data,
  output logic                o_serial_clk,
  output logic                o_serial_latch,
  output logic [1:0]          o_dbg_state
);

  localparam int HALF_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int HW       = $clog2(HALF + 1);
  localparam int BW       = $clog2(NUM_BITS + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [BW-1:0] BITS_INIT = BW'(NUM_BITS);
  localparam logic [BW-1:0] BITS_ONE  = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLK_LOW  = 2'd1,
    S_CLK_HIGH = 2'd2,
    S_LATCH    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       half_q, half_d;
  logic [BW-1:0]       bits_q, bits_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                half_end;
  logic                busy_d, done_d, sdata_d, sclk_d, latch_d;
  logic                cur_bit;

  // Handshake: a frame is accepted on any edge where i_start && i_en and o_busy is low;
  // requests while o_busy is high are dropped, never queued. o_done marks completion.

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    half_end = (half_q == HALF_LAST);
    case (state_q)
      S_IDLE: begin
        if (i_start && i_en) begin
          shift_d = i_data;
          bits_d  = BITS_INIT;
          half_d  = '0;
          state_d = S_CLK_LOW;
        end
      end
      S_CLK_LOW: begin
        if (half_end) begin
          half_d  = '0;
          state_d = S_CLK_HIGH;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_CLK_HIGH: begin
        if (half_end) begin
          half_d = '0;
`ifdef DISPLAY_SHIFT_LSB_FIRST_EN
          shift_d = shift_q >> 1;
`else
          shift_d = shift_q << 1;
`endif
          bits_d  = bits_q - 1'b1;
          state_d = (bits_q == BITS_ONE) ? S_LATCH : S_CLK_LOW;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (half_end) begin
          half_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state register.
  always_comb begin
`ifdef DISPLAY_SHIFT_LSB_FIRST_EN
    cur_bit = shift_d[0];
`else
    cur_bit = shift_d[NUM_BITS-1];
`endif
    busy_d  = (state_d != S_IDLE);
    sclk_d  = (state_d == S_CLK_HIGH);
    latch_d = (state_d == S_LATCH);
    sdata_d = (state_d == S_CLK_LOW || state_d == S_CLK_HIGH) ? cur_bit : 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      half_q         <= '0;
      bits_q         <= '0;
      shift_q        <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_serial_data  <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
    end else begin
      state_q        <= state_d;
      half_q         <= half_d;
      bits_q         <= bits_d;
      shift_q        <= shift_d;
      o_busy         <= busy_d;
      o_done         <= done_d;
      o_serial_data  <= sdata_d;
      o_serial_clk   <= sclk_d;
      o_serial_latch <= latch_d;
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_display_shift_driver.sv
// Directed bench for display_shift_driver: default instance plus a HALF=1, 8-bit instance.
module tb_display_shift_driver;

  localparam int HALF0 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en0 = 1'b1, start0 = 1'b0;
  logic [31:0] data0 = '0;
  logic        busy0, done0, sdata0, sclk0, latch0;
  logic [1:0]  dbg0;

  logic        start1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        busy1, done1, sdata1, sclk1, latch1;
  logic [1:0]  dbg1;

  display_shift_driver dut0 (
    .i_clk(clk), .i_reset(rst), .i_en(en0), .i_start(start0), .i_data(data0),
    .o_busy(busy0), .o_done(done0), .o_serial_data(sdata0), .o_serial_clk(sclk0),
    .o_serial_latch(latch0), .o_dbg_state(dbg0)
  );

  display_shift_driver #(.SYS_CLK_HZ(1_000_000), .SHIFT_CLK_HZ(1_000_000), .NUM_BITS(8)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_en(1'b1), .i_start(start1), .i_data(data1),
    .o_busy(busy1), .o_done(done1), .o_serial_data(sdata1), .o_serial_clk(sclk1),
    .o_serial_latch(latch1), .o_dbg_state(dbg1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] d);
    for (int i = 0; i < 32; i++) begin
`ifdef DISPLAY_SHIFT_LSB_FIRST_EN
      exp_q.push_back(d[i]);
`else
      exp_q.push_back(d[31-i]);
`endif
    end
  endtask

  // Serial monitor for the default instance: bit scoreboard plus clock run lengths.
  logic prev_sclk = 1'b0;
  int   hi_run = 0, lo_run = 0;
  always @(negedge clk) begin
    logic [0:0] exp_bit;
    if (rst) begin
      prev_sclk = 1'b0;
      hi_run    = 0;
      lo_run    = 0;
    end else begin
      if (sclk0 && !prev_sclk) begin
        check("low_run", lo_run, HALF0);
        lo_run = 0;
        if (exp_q.size() == 0) check("extra_bit", exp_q.size(), 1);
        else begin
          exp_bit = exp_q.pop_front();
          check("serial_bit", sdata0, exp_bit);
        end
      end
      if (!sclk0 && prev_sclk) begin
        check("high_run", hi_run, HALF0);
        hi_run = 0;
      end
      if (sclk0) hi_run++;
      else if (busy0 && !latch0) lo_run++;
      if (latch0) check("latch_vs_clk", sclk0, 0);
      prev_sclk = sclk0;
    end
  end

  int b_cnt, b_first, b_last, l_cnt, l_first, l_last, d_cnt, d_at, rises;

  task automatic measure0(input int ncyc, input int pulse_at, input int release_at);
    logic p;
    b_cnt = 0; b_first = 0; b_last = 0; l_cnt = 0; l_first = 0; l_last = 0;
    d_cnt = 0; d_at = 0; rises = 0;
    p = sclk0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (busy0) begin b_cnt++; if (b_first == 0) b_first = k; b_last = k; end
      if (latch0) begin l_cnt++; if (l_first == 0) l_first = k; l_last = k; end
      if (done0) begin d_cnt++; if (d_at == 0) d_at = k; end
      if (sclk0 && !p) rises++;
      p = sclk0;
      if (k == pulse_at) begin start0 = 1'b1; data0 = $urandom; end
      if (k == release_at) start0 = 1'b0;
    end
  endtask

  task automatic launch0(input logic [31:0] d, input bit keep);
    @(posedge clk); #1;
    data0  = d;
    start0 = 1'b1;
    push_frame(d);
    @(posedge clk); #1;
    if (!keep) start0 = 1'b0;
  endtask

  initial begin
    logic [7:0] cap;
    int hi1, hi1_max, lo1, lo1_max, b1, r1, d1_at;
    logic p1;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs0", {busy0, done0, sdata0, sclk0, latch0}, 5'b0);
    check("reset_state0", dbg0, 2'd0);
    check("reset_outs1", {busy1, done1, sdata1, sclk1, latch1}, 5'b0);
    rst = 1'b0;

    // Single frame, default timing
    launch0(32'hA5C3_0F81, 1'b0);
    measure0(140, 0, 0);
    check("busy_cnt", b_cnt, 130);
    check("busy_first", b_first, 1);
    check("busy_last", b_last, 130);
    check("sclk_rises", rises, 32);
    check("latch_first", l_first, 129);
    check("latch_last", l_last, 130);
    check("done_cnt", d_cnt, 1);
    check("done_at", d_at, 131);

    // Start pulse and data change while busy are ignored
    launch0($urandom, 1'b0);
    measure0(140, 20, 21);
    check("gate_busy_cnt", b_cnt, 130);
    check("gate_rises", rises, 32);
    check("gate_done_cnt", d_cnt, 1);

    // Start with enable low is ignored
    @(posedge clk); #1;
    en0 = 1'b0;
    start0 = 1'b1;
    measure0(10, 0, 0);
    check("en_low_busy", b_cnt, 0);
    start0 = 1'b0;
    en0 = 1'b1;

    // Single-one frame; enable dropped mid-frame must not stop it
    launch0(32'h0000_0001, 1'b0);
    en0 = 1'b0;
    measure0(140, 0, 0);
    en0 = 1'b1;
    check("one_busy_cnt", b_cnt, 130);
    check("one_done_at", d_at, 131);

    // Back-to-back frames with start held
    launch0(32'hFFFF_FFFF, 1'b1);
    data0 = 32'h0000_0000;
    push_frame(32'h0000_0000);
    measure0(280, 0, 132);
    check("b2b_busy_cnt", b_cnt, 260);
    check("b2b_gap", (b_last - b_first + 1) - b_cnt, 1);
    check("b2b_done_cnt", d_cnt, 2);
    check("b2b_rises", rises, 64);

    // Reset mid-frame aborts without o_done
    launch0(32'h1234_5678, 1'b0);
    measure0(40, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outs", {busy0, done0, sdata0, sclk0, latch0}, 5'b0);
    check("abort_state", dbg0, 2'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    measure0(10, 0, 0);
    check("abort_no_done", d_cnt, 0);
    check("abort_idle", b_cnt, 0);
    launch0(32'h5A5A_C3C3, 1'b0);
    measure0(140, 0, 0);
    check("post_reset_busy", b_cnt, 130);
    check("post_reset_rises", rises, 32);
    check("post_reset_done", d_at, 131);

    // HALF=1 instance, 8-bit frame
    @(posedge clk); #1;
    data1  = 8'h3C;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cap = '0; hi1 = 0; hi1_max = 0; lo1 = 0; lo1_max = 0; b1 = 0; r1 = 0; d1_at = 0;
    p1 = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (busy1) b1++;
      if (done1 && d1_at == 0) d1_at = k;
      if (sclk1 && !p1) begin
        r1++;
`ifdef DISPLAY_SHIFT_LSB_FIRST_EN
        cap = {sdata1, cap[7:1]};
`else
        cap = {cap[6:0], sdata1};
`endif
        if (lo1 > lo1_max) lo1_max = lo1;
        lo1 = 0;
      end
      if (sclk1) hi1++;
      else begin
        if (hi1 > hi1_max) hi1_max = hi1;
        hi1 = 0;
        if (busy1 && !latch1) lo1++;
      end
      p1 = sclk1;
    end
    check("h1_busy_cnt", b1, 17);
    check("h1_rises", r1, 8);
    check("h1_capture", cap, 8'h3C);
    check("h1_high_run", hi1_max, 1);
    check("h1_low_run", lo1_max, 1);
    check("h1_done_at", d1_at, 18);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
